ysyx_22050710_fetch_queue_stage: RTL
====================================

Name: ysyx_22050710_fetch_queue_stage

Overview:
Next-generation instruction fetch stage that decouples PC generation from decode. It uses a split request/response instruction SRAM handshake with up to MAX_OUTSTANDING in-flight requests. Returned instructions go into a DEPTH-entry fetch queue, which feeds the decode stage under valid/allowin back-pressure. A branch redirect flushes the queue and discards stale responses using an epoch bit.

Parameters:
INST_WD, 32, instruction width
PC_WD, 32, PC width
FS_TO_DS_BUS_WD, 64, {inst, pc} bus width; must equal INST_WD+PC_WD
BR_BUS_WD, 33, {br_sel, br_target} width; must equal 1+PC_WD
SRAM_ADDR_WD, 32, inst SRAM address width
SRAM_DATA_WD, 32, inst SRAM read data width; must be at least INST_WD
RESET_PC, 32'h8000_0000, first fetch address after reset
DEPTH, 4, fetch queue entries (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum in-flight SRAM requests (power of 2, >=1)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_br_bus  in  BR_BUS_WD  {br_sel, br_target} redirect from execute
i_ds_allowin  in  1  decode can accept this cycle
o_fs_to_ds_valid  out  1  queue head valid
o_fs_to_ds_bus  out  FS_TO_DS_BUS_WD  {inst, pc} of queue head
o_inst_sram_req  out  1  request valid
o_inst_sram_addr  out  SRAM_ADDR_WD  request address (current PC, zero-extended or truncated)
i_inst_sram_gnt  in  1  request accepted this cycle
i_inst_sram_rvalid  in  1  response valid; responses return in order, at least 1 cycle after gnt
i_inst_sram_rdata  in  SRAM_DATA_WD  response data; low INST_WD bits used

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is asynchronous, active-high.
- Reset values:
  - pc=RESET_PC, epoch=0.
  - queue and in-flight tracker empty; outstanding=0.
  - o_fs_to_ds_valid=0, o_inst_sram_req=0, o_fs_to_ds_bus=0.
  - The first request is raised in the first cycle after reset deasserts.
- Credit rule: o_inst_sram_req = !br_sel && (outstanding < MAX_OUTSTANDING) && (queue_count + outstanding < DEPTH). Every accepted request is therefore guaranteed a queue slot.
- Issue: on req && gnt:
  - push {pc, epoch} into the in-flight tracker;
  - outstanding += 1;
  - pc <= pc + 4, wrapping modulo 2^PC_WD.
  - Without gnt, req and addr hold stable.
- Response: on rvalid, pop the tracker head and decrement outstanding.
  - Tag epoch == current epoch and no redirect this cycle: push {rdata[INST_WD-1:0], tag_pc} into the queue.
  - Otherwise: drop the response.
- Issue and response in the same cycle: outstanding is unchanged.
- Dequeue: o_fs_to_ds_valid = queue non-empty && !br_sel. Pop when valid && i_ds_allowin. The bus shows the head combinationally from queue storage.
- Simultaneous push and pop: count is unchanged. The queue never overflows (credit rule). An rvalid with the tracker empty is a protocol error, flagged by a simulation assertion; RTL ignores it.
- Redirect (br_sel=1), effective in the same cycle:
  - pc <= {br_target[PC_WD-1:2], 2'b00};
  - epoch toggles;
  - queue count reset to 0;
  - no request issued; no dequeue presented.
  - Outstanding and tracker entries are kept; their later responses carry the old epoch and are dropped.
- Back-to-back redirects: each toggles epoch. Responses are strictly ordered, so a 1-bit epoch is sufficient.
- Latency: gnt at cycle N, rvalid at N+1 -> o_fs_to_ds_valid at N+2.
- Sustained throughput: 1 inst/cycle when gnt and rvalid are continuous and MAX_OUTSTANDING>=2.

Optional Feature:
YSYX_22050710_FETCH_PERF_EN.
- Defined: adds outputs o_perf_fetch_cnt[63:0] (instructions dequeued to decode), o_perf_flush_cnt[31:0] (redirect cycles) and o_perf_drop_cnt[31:0] (stale responses discarded). All reset to 0, saturate at all-ones, count in the same cycle as the event.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared defines header: bus width relations, RESET_PC default, perf counter widths.
- Sub-module ysyx_22050710_sync_fifo (parametrised WIDTH, DEPTH; push, pop, flush, full, empty, count) is instantiated twice:
  - fetch queue: WIDTH=INST_WD+PC_WD, flush on redirect;
  - in-flight tracker: WIDTH=PC_WD+1, never flushed.

Test Plan:
- Reset release, gnt=1, rvalid 1 cycle later, allowin=1 -> addrs 0x80000000, 0x80000004, ...; bus pcs appear in order from cycle 2; 1 inst/cycle.
- allowin=0 with DEPTH=4 -> exactly 4 entries buffered, req drops to 0 once count+outstanding=4; allowin=1 resumes with no loss or duplication.
- Redirect to 0x80001003 while 2 requests are outstanding -> next addr 0x80001000; the 2 stale responses are dropped; first valid bus pc is 0x80001000.
- Redirect in the same cycle as rvalid and a dequeue -> response dropped, valid=0 that cycle, queue empty next cycle.
- gnt held low for 5 cycles -> addr stable, no tracker push; wrap test: pc=0xFFFFFFFC -> next 0x00000000.
- With YSYX_22050710_FETCH_PERF_EN, 10 fetches and 1 redirect dropping 2 -> fetch_cnt=10, flush_cnt=1, drop_cnt=2.

Source files
------------

// File: rtl/ysyx_22050710_fetch_queue_stage_pkg.sv
// Shared constants for the fetch queue stage: bus width relations, reset PC
// default and performance counter widths.
package ysyx_22050710_fetch_queue_stage_pkg;

    localparam int          INST_WD_DEF       = 32;
    localparam int          PC_WD_DEF         = 32;
    localparam logic [31:0] RESET_PC_DEF      = 32'h8000_0000;
    localparam int          PERF_FETCH_CNT_WD = 64;
    localparam int          PERF_FLUSH_CNT_WD = 32;
    localparam int          PERF_DROP_CNT_WD  = 32;

    function automatic int fs_to_ds_bus_wd(input int inst_wd, input int pc_wd);
        return inst_wd + pc_wd;
    endfunction

    function automatic int br_bus_wd(input int pc_wd);
        return 1 + pc_wd;
    endfunction

    // A single-entry FIFO still needs a 1-bit pointer to stay legal.
    function automatic int ptr_wd(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22050710_sync_fifo.sv
// Synchronous FIFO with occupancy count and a single-cycle flush; used both as
// the fetch queue and as the in-flight request tracker.
module ysyx_22050710_sync_fifo
    import ysyx_22050710_fetch_queue_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    input  logic                         flush,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_WD   = ptr_wd(DEPTH);
    localparam int COUNT_WD = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_WD-1:0] wr_ptr;
    logic [PTR_WD-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
        return (p == PTR_WD'(DEPTH - 1)) ? '0 : p + PTR_WD'(1);
    endfunction

    assign full     = (count == COUNT_WD'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + COUNT_WD'(1);
            else if (!do_push && do_pop) count <= count - COUNT_WD'(1);
        end
    end

    // Storage is cleared on reset so the head reads as zero before any push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ysyx_22050710_fetch_queue_stage.sv
// Decoupled fetch stage: credit-limited SRAM requests, epoch-tagged in-flight
// tracker, fetch queue toward decode. YSYX_22050710_FETCH_PERF_EN adds perf counters.
module ysyx_22050710_fetch_queue_stage
    import ysyx_22050710_fetch_queue_stage_pkg::*;
#(
    parameter int               INST_WD         = INST_WD_DEF,
    parameter int               PC_WD           = PC_WD_DEF,
    parameter int               FS_TO_DS_BUS_WD = fs_to_ds_bus_wd(INST_WD, PC_WD),
    parameter int               BR_BUS_WD       = br_bus_wd(PC_WD),
    parameter int               SRAM_ADDR_WD    = 32,
    parameter int               SRAM_DATA_WD    = 32,
    parameter logic [PC_WD-1:0] RESET_PC        = PC_WD'(RESET_PC_DEF),
    parameter int               DEPTH           = 4,
    parameter int               MAX_OUTSTANDING = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [BR_BUS_WD-1:0]        i_br_bus,
    input  logic                        i_ds_allowin,
    output logic                        o_fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0]  o_fs_to_ds_bus,
    output logic                        o_inst_sram_req,
    output logic [SRAM_ADDR_WD-1:0]     o_inst_sram_addr,
    input  logic                        i_inst_sram_gnt,
    input  logic                        i_inst_sram_rvalid,
    input  logic [SRAM_DATA_WD-1:0]     i_inst_sram_rdata
`ifdef YSYX_22050710_FETCH_PERF_EN
   ,output logic [PERF_FETCH_CNT_WD-1:0] o_perf_fetch_cnt
   ,output logic [PERF_FLUSH_CNT_WD-1:0] o_perf_flush_cnt
   ,output logic [PERF_DROP_CNT_WD-1:0]  o_perf_drop_cnt
`endif
);

    localparam int Q_CNT_WD   = $clog2(DEPTH + 1);
    localparam int TRK_CNT_WD = $clog2(MAX_OUTSTANDING + 1);

    logic                       br_sel;
    logic [PC_WD-1:0]           br_target;
    logic [PC_WD-1:0]           pc;
    logic                       epoch;
    logic                       issue;
    logic                       resp;
    logic                       accept;
    logic                       drop;
    logic                       deq;
    logic                       credit_ok;
    logic [PC_WD:0]             trk_head;
    logic                       trk_full;
    logic                       trk_empty;
    logic [TRK_CNT_WD-1:0]      trk_count;
    logic [FS_TO_DS_BUS_WD-1:0] q_push_data;
    logic                       q_full;
    logic                       q_empty;
    logic [Q_CNT_WD-1:0]        q_count;
    logic                       unused_bits;

    assign {br_sel, br_target} = i_br_bus;
    assign unused_bits = ^{br_target[1:0], q_full, trk_full, i_inst_sram_rdata};

    // Every granted request already owns a queue slot, so the queue cannot overflow.
    assign credit_ok = (32'(trk_count) < 32'(MAX_OUTSTANDING)) &&
                       (32'(q_count) + 32'(trk_count) < 32'(DEPTH));

    assign o_inst_sram_req  = !i_rst && !br_sel && credit_ok;
    assign o_inst_sram_addr = SRAM_ADDR_WD'(pc);
    assign issue            = o_inst_sram_req && i_inst_sram_gnt;

    assign resp        = i_inst_sram_rvalid && !trk_empty;
    assign accept      = resp && (trk_head[0] == epoch) && !br_sel;
    assign drop        = resp && !accept;
    assign q_push_data = {i_inst_sram_rdata[INST_WD-1:0], trk_head[PC_WD:1]};

    assign o_fs_to_ds_valid = !q_empty && !br_sel;
    assign deq              = o_fs_to_ds_valid && i_ds_allowin;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc    <= RESET_PC;
            epoch <= 1'b0;
        end else if (br_sel) begin
            pc    <= {br_target[PC_WD-1:2], 2'b00};
            epoch <= ~epoch;
        end else if (issue) begin
            pc    <= pc + PC_WD'(4);
        end
    end

    ysyx_22050710_sync_fifo #(
        .WIDTH (PC_WD + 1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tracker (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (issue),
        .push_data ({pc, epoch}),
        .pop       (resp),
        .pop_data  (trk_head),
        .flush     (1'b0),
        .full      (trk_full),
        .empty     (trk_empty),
        .count     (trk_count)
    );

    ysyx_22050710_sync_fifo #(
        .WIDTH (FS_TO_DS_BUS_WD),
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (accept),
        .push_data (q_push_data),
        .pop       (deq),
        .pop_data  (o_fs_to_ds_bus),
        .flush     (br_sel),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

`ifdef YSYX_22050710_FETCH_PERF_EN
    // Saturating event counters, each bumped in the cycle of its event.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_perf_fetch_cnt <= '0;
            o_perf_flush_cnt <= '0;
            o_perf_drop_cnt  <= '0;
        end else begin
            if (deq && !(&o_perf_fetch_cnt))
                o_perf_fetch_cnt <= o_perf_fetch_cnt + PERF_FETCH_CNT_WD'(1);
            if (br_sel && !(&o_perf_flush_cnt))
                o_perf_flush_cnt <= o_perf_flush_cnt + PERF_FLUSH_CNT_WD'(1);
            if (drop && !(&o_perf_drop_cnt))
                o_perf_drop_cnt  <= o_perf_drop_cnt + PERF_DROP_CNT_WD'(1);
        end
    end
`endif

    tracker_underflow_a: assert property (@(posedge i_clk) disable iff (i_rst)
        i_inst_sram_rvalid |-> !trk_empty);

endmodule
